// File: rtl/sincos_angle_recover.sv
// Recovers a 10-bit phase angle from a 5-bit signed sine/cosine pair using an
// iterative vectoring CORDIC: quadrant pre-rotation at load, one micro-rotation per clock.
`timescale 1ns/1ps

module sincos_angle_recover #(
  parameter int unsigned ITER = 8
) (
  input  logic       clk,
  input  logic       areset,
  input  logic [4:0] s,
  input  logic [4:0] c,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [9:0] a,
  output logic       a_zero,
  output logic       out_valid,
  input  logic       out_ready
);

  localparam logic [2:0] LastIter = 3'(ITER - 1);

  typedef enum logic [1:0] {StIdle, StRot, StDone} state_e;

  state_e             state_q;
  logic        [2:0]  i_q;
  logic signed [9:0]  x_q, y_q;
  logic        [13:0] z_q;
  logic               zero_q;

  logic signed [9:0]  s_ext, c_ext;
  logic signed [9:0]  x_load, y_load;
  logic        [13:0] z_load;
  logic signed [9:0]  x_sh, y_sh;
  logic signed [9:0]  x_rot, y_rot;
  logic        [13:0] z_rot;
  logic        [9:0]  a_next;

  // atan(2^-i) in 1/16 angle units; 16384 units span a full turn.
  function automatic logic [13:0] atan_lut(input logic [2:0] idx);
    logic [13:0] t;
    case (idx)
      3'd0:    t = 14'd2048;
      3'd1:    t = 14'd1209;
      3'd2:    t = 14'd639;
      3'd3:    t = 14'd324;
      3'd4:    t = 14'd163;
      3'd5:    t = 14'd81;
      3'd6:    t = 14'd41;
      default: t = 14'd20;
    endcase
    return t;
  endfunction

  // Left half-plane inputs are mirrored through the origin and start at pi, so the
  // rotation loop only ever has to cover -pi/2..pi/2.
  always_comb begin
    s_ext = {{5{s[4]}}, s};
    c_ext = {{5{c[4]}}, c};
    if (c[4]) begin
      x_load = -(c_ext <<< 3);
      y_load = -(s_ext <<< 3);
      z_load = 14'd8192;
    end else begin
      x_load = c_ext <<< 3;
      y_load = s_ext <<< 3;
      z_load = 14'd0;
    end
  end

  always_comb begin
    x_sh = x_q >>> i_q;
    y_sh = y_q >>> i_q;
    if (!y_q[9]) begin
      x_rot = x_q + y_sh;
      y_rot = y_q - x_sh;
      z_rot = z_q + atan_lut(i_q);
    end else begin
      x_rot = x_q - y_sh;
      y_rot = y_q + x_sh;
      z_rot = z_q - atan_lut(i_q);
    end
    // Round to nearest and drop the fraction; the 14-bit sum wraps like the angle does.
    a_next = 10'((z_rot + 14'd8) >> 4);
  end

  always_ff @(posedge clk or negedge areset) begin
    if (!areset) begin
      state_q   <= StIdle;
      i_q       <= 3'd0;
      x_q       <= '0;
      y_q       <= '0;
      z_q       <= '0;
      zero_q    <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      a         <= '0;
      a_zero    <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid && in_ready) begin
            x_q      <= x_load;
            y_q      <= y_load;
            z_q      <= z_load;
            zero_q   <= (s == 5'd0) && (c == 5'd0);
            i_q      <= 3'd0;
            in_ready <= 1'b0;
            state_q  <= StRot;
          end
        end
        StRot: begin
          x_q <= x_rot;
          y_q <= y_rot;
          z_q <= z_rot;
          i_q <= i_q + 3'd1;
          if (i_q == LastIter) begin
            a         <= zero_q ? 10'd0 : a_next;
            a_zero    <= zero_q;
            out_valid <= 1'b1;
            state_q   <= StDone;
          end
        end
        StDone: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state_q   <= StIdle;
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sincos_angle_recover.sv
// Self-checking bench for sincos_angle_recover: cardinal/diagonal vectors against ideal
// angles, handshake corner cases, and random/sweep inputs against an integer CORDIC model.
`timescale 1ns/1ps

module tb_sincos_angle_recover;

  localparam int unsigned Iter = 8;
  localparam int Tol = 2;

  logic       clk = 1'b0;
  logic       areset = 1'b0;
  logic [4:0] s = '0;
  logic [4:0] c = '0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [9:0] a;
  logic       a_zero;
  logic       out_valid;
  logic       out_ready = 1'b0;

  int n_checks = 0;
  int n_fail = 0;

  typedef struct {
    int s;
    int c;
    int exp_a;
    int exp_z;
  } vec_t;

  always #5 clk = ~clk;

  sincos_angle_recover #(
    .ITER(Iter)
  ) dut (
    .clk      (clk),
    .areset   (areset),
    .s        (s),
    .c        (c),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .a_zero   (a_zero),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  task automatic check_eq(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  // Angles compare on the circle, so 1023 is 1 LSB away from 0.
  task automatic check_near(input string name, input int got, input int exp, input int tol);
    int d;
    d = (((got - exp) % 1024) + 1024) % 1024;
    if (d > 512) d = 1024 - d;
    n_checks++;
    if (d > tol) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d +/- %0d", name, got, exp, tol);
    end
  endtask

  // Bit-exact model of the conversion, written with plain integer arithmetic.
  function automatic int model_angle(input int sv, input int cv);
    int t[8];
    int x, y, z, dx, dy;
    t = '{2048, 1209, 639, 324, 163, 81, 41, 20};
    if (sv == 0 && cv == 0) return 0;
    if (cv >= 0) begin
      x = cv * 8; y = sv * 8; z = 0;
    end else begin
      x = -cv * 8; y = -sv * 8; z = 8192;
    end
    for (int i = 0; i < int'(Iter); i++) begin
      dx = x >>> i;
      dy = y >>> i;
      if (y >= 0) begin
        x = x + dy; y = y - dx; z = z + t[i];
      end else begin
        x = x - dy; y = y + dx; z = z - t[i];
      end
    end
    return ((z + 8) & 16383) >> 4;
  endfunction

  task automatic wait_ready();
    int n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    check_eq("in_ready_wait", int'(in_ready), 1);
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1; lat++;
    end
    check_eq("out_valid_wait", int'(out_valid), 1);
  endtask

  task automatic convert(input int sv, input int cv, output int got_a, output int got_z,
                         output int lat);
    wait_ready();
    s = 5'(sv);
    c = 5'(cv);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_out(lat);
    got_a = int'(a);
    got_z = int'(a_zero);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[11];
    int got_a, got_z, lat, a_hold, sv, cv, k;
    real ang;

    vecs = '{
      '{0,   15,  0,    0},
      '{15,  0,   256,  0},
      '{0,   -15, 512,  0},
      '{-15, 0,   768,  0},
      '{11,  11,  128,  0},
      '{11,  -11, 384,  0},
      '{-11, -11, 640,  0},
      '{-1,  15,  1013, 0},
      '{-16, -16, 640,  0},
      '{15,  -16, 389,  0},
      '{0,   0,   0,    1}
    };

    // Reset state
    #12;
    check_eq("rst_in_ready", int'(in_ready), 1);
    check_eq("rst_out_valid", int'(out_valid), 0);
    check_eq("rst_a", int'(a), 0);
    check_eq("rst_a_zero", int'(a_zero), 0);
    @(negedge clk);
    areset = 1'b1;
    @(posedge clk); #1;

    // Directed vectors
    for (int i = 0; i < 11; i++) begin
      convert(vecs[i].s, vecs[i].c, got_a, got_z, lat);
      if (vecs[i].exp_z != 0) check_eq($sformatf("vec%0d_a", i), got_a, 0);
      else check_near($sformatf("vec%0d_a", i), got_a, vecs[i].exp_a, Tol);
      check_eq($sformatf("vec%0d_a_zero", i), got_z, vecs[i].exp_z);
      check_eq($sformatf("vec%0d_latency", i), lat, int'(Iter));
    end

    // Backpressure: result holds in DONE and new input is ignored until released
    wait_ready();
    s = 5'(11); c = 5'(11); in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_out(lat);
    a_hold = int'(a);
    check_near("bp_first_a", a_hold, 128, Tol);
    s = 5'(0); c = 5'(15); in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check_eq("bp_a_stable", int'(a), a_hold);
      check_eq("bp_out_valid", int'(out_valid), 1);
      check_eq("bp_in_ready", int'(in_ready), 0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check_eq("bp_release_out_valid", int'(out_valid), 0);
    check_eq("bp_release_in_ready", int'(in_ready), 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check_eq("bp_second_accept", int'(in_ready), 0);
    wait_out(lat);
    check_eq("bp_second_latency", lat, int'(Iter));
    check_near("bp_second_a", int'(a), 0, Tol);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;

    // Reset mid-conversion, with a nonzero previous result on a
    convert(11, -11, got_a, got_z, lat);
    check_near("pre_rst_a", got_a, 384, Tol);
    wait_ready();
    s = 5'(11); c = 5'(11); in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    areset = 1'b0;
    #1;
    check_eq("midrst_in_ready", int'(in_ready), 1);
    check_eq("midrst_out_valid", int'(out_valid), 0);
    check_eq("midrst_a", int'(a), 0);
    @(negedge clk);
    areset = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    check_eq("midrst_no_output", int'(out_valid), 0);
    convert(15, 0, got_a, got_z, lat);
    check_near("postrst_a", got_a, 256, Tol);
    check_eq("postrst_latency", lat, int'(Iter));

    // Random pairs against the model
    for (int i = 0; i < 300; i++) begin
      sv = int'($urandom_range(31)) - 16;
      cv = int'($urandom_range(31)) - 16;
      convert(sv, cv, got_a, got_z, lat);
      check_eq($sformatf("rnd_a(s=%0d,c=%0d)", sv, cv), got_a, model_angle(sv, cv));
      check_eq($sformatf("rnd_z(s=%0d,c=%0d)", sv, cv), got_z,
               (sv == 0 && cv == 0) ? 1 : 0);
    end

    // Loopback sweep of quantised sine/cosine pairs over a full turn
    for (int i = 0; i < 1024; i++) begin
      ang = 2.0 * 3.14159265358979 * real'(i) / 1024.0;
      sv = int'(15.0 * $sin(ang));
      cv = int'(15.0 * $cos(ang));
      convert(sv, cv, got_a, got_z, lat);
      k = model_angle(sv, cv);
      check_eq($sformatf("sweep%0d_a", i), got_a, k);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
